// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the MIPS-subset control logic. Holds
//               the 3-bit opcode constants, the multi-cycle state encoding,
//               the one-hot instruction class produced by op_decode, and the
//               datapath mux / ALU operation encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Opcode field bits [2:0]
    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_R    = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_J    = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    // Sequencer states, fixed 4-bit encoding
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADDR = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_REXEC   = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_IEXEC   = 4'd10,
        ST_IWB     = 4'd11,
        ST_HALT    = 4'd12
    } state_e;

    // One-hot instruction class; all zero when the opcode is illegal
    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic j;
        logic beq;
        logic bne;
        logic addi;
        logic halt;
    } op_class_t;

    // ALU B-input select
    localparam logic [1:0] ALUSRCB_RT   = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Controller <-> datapath bundle. The master modport is the
//               controller: it receives opcode/zero/mem_ready and drives all
//               control strobes, mux selects and status. The slave modport is
//               the datapath side.
// Parameters  : OPW   - opcode field width
//               CNT_W - retired-instruction counter width
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int OPW   = 8,
    parameter int CNT_W = 16
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             mem_ready;
    logic             irwrite;
    logic             pcwrite;
    logic [1:0]       pcsrc;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             regdest;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output irwrite, pcwrite, pcsrc, iord, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, alusrcb, aluop, halted, illegal,
               retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  irwrite, pcwrite, pcsrc, iord, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, alusrcb, aluop, halted, illegal,
               retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : op_decode
// Description : Combinational opcode classifier shared by the single-cycle
//               and multi-cycle controllers.
// Ports       : opcode   (in)  OPW-bit opcode field
//               op_class (out) one-hot instruction class, zero if illegal
//               illegal  (out) any bit above [2:0] is set
// Revision    : 1.0 - initial release
// ============================================================================
module op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 8
) (
    input  wire logic [OPW-1:0] opcode,
    output op_class_t           op_class,
    output logic                illegal
);
    logic w_upper_nz;

    generate
        if (OPW > 3) begin : g_upper
            assign w_upper_nz = |opcode[OPW-1:3];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        op_class = '0;
        illegal  = w_upper_nz;
        if (!w_upper_nz) begin
            case (opcode[2:0])
                OP_HALT: op_class.halt  = 1'b1;
                OP_R:    op_class.rtype = 1'b1;
                OP_LW:   op_class.lw    = 1'b1;
                OP_SW:   op_class.sw    = 1'b1;
                OP_J:    op_class.j     = 1'b1;
                OP_BEQ:  op_class.beq   = 1'b1;
                OP_BNE:  op_class.bne   = 1'b1;
                default: op_class.addi  = 1'b1;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle sequencer for the MIPS-subset datapath. Steps
//               each instruction through fetch/decode/execute/memory/
//               writeback, with a ready handshake on memory states, and
//               halts on opcode 000 or any illegal opcode.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high
//               bus   - multicycle_control_if.master (opcode/zero/mem_ready
//                       in; control strobes, selects, halted, illegal,
//                       retired out)
// Options     : PERF_CNT_EN - when defined, a saturating retired-instruction
//               counter drives bus.retired; otherwise bus.retired is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW   = 8,
    parameter int CNT_W = 16
) (
    input wire logic             clk,
    input wire logic             reset,
    multicycle_control_if.master bus
);
    state_e     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;

    op_class_t  w_dec_class;
    logic       w_dec_illegal;

    op_decode #(.OPW(OPW)) u_op_decode (
        .opcode   (bus.opcode),
        .op_class (w_dec_class),
        .illegal  (w_dec_illegal)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH:   if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                // Later states see only this latched copy of the opcode
                opcode_d = bus.opcode[2:0];
                if (w_dec_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
                else if (w_dec_class.lw || w_dec_class.sw)   state_d = ST_MEMADDR;
                else if (w_dec_class.rtype)                  state_d = ST_REXEC;
                else if (w_dec_class.addi)                   state_d = ST_IEXEC;
                else if (w_dec_class.beq || w_dec_class.bne) state_d = ST_BRANCH;
                else if (w_dec_class.j)                      state_d = ST_JUMP;
                else if (w_dec_class.halt)                   state_d = ST_HALT;
                else                                         state_d = ST_HALT;
            end
            ST_MEMADDR: state_d = (opcode_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   if (bus.mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:   state_d = ST_FETCH;
            ST_MEMWR:   if (bus.mem_ready) state_d = ST_FETCH;
            ST_REXEC:   state_d = ST_RWB;
            ST_RWB:     state_d = ST_FETCH;
            ST_IEXEC:   state_d = ST_IWB;
            ST_IWB:     state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------ outputs
    logic       w_irwrite, w_pcwrite, w_iord, w_memread, w_memwrite;
    logic       w_memtoreg, w_regdest, w_regwrite, w_alusrca;
    logic [1:0] w_pcsrc, w_alusrcb, w_aluop;

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_pcsrc    = PCSRC_ALU;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regdest  = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = ALUSRCB_RT;
        w_aluop    = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = ALUSRCB_ONE;
                // IR and PC+1 commit only on the cycle the fetch completes
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
            end
            ST_DECODE:  w_alusrcb = ALUSRCB_BOFF;
            ST_MEMADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUSRCB_IMM;
            end
            ST_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            ST_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            ST_REXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                w_regwrite = 1'b1;
                w_regdest  = 1'b1;
            end
            ST_IEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUSRCB_IMM;
            end
            ST_IWB:     w_regwrite = 1'b1;
            ST_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_pcsrc   = PCSRC_ALUOUT;
                w_pcwrite = ((opcode_q == OP_BEQ) &&  bus.zero) ||
                            ((opcode_q == OP_BNE) && !bus.zero);
            end
            ST_JUMP: begin
                w_pcsrc   = PCSRC_JUMP;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Strobes must not fire during reset even though state is still old
        if (reset) begin
            w_irwrite  = 1'b0;
            w_pcwrite  = 1'b0;
            w_memread  = 1'b0;
            w_memwrite = 1'b0;
            w_regwrite = 1'b0;
        end
    end

    assign bus.irwrite  = w_irwrite;
    assign bus.pcwrite  = w_pcwrite;
    assign bus.pcsrc    = w_pcsrc;
    assign bus.iord     = w_iord;
    assign bus.memread  = w_memread;
    assign bus.memwrite = w_memwrite;
    assign bus.memtoreg = w_memtoreg;
    assign bus.regdest  = w_regdest;
    assign bus.regwrite = w_regwrite;
    assign bus.alusrca  = w_alusrca;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.aluop    = w_aluop;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.illegal  = illegal_q;

    // ----------------------------------------------- retired-instruction count
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             w_retire;

    // An instruction retires when a completing state hands back to FETCH
    assign w_retire = (state_q inside {ST_MEMWB, ST_MEMWR, ST_RWB, ST_IWB,
                                       ST_BRANCH, ST_JUMP}) &&
                      (state_d == ST_FETCH);

    always_comb begin
        retired_d = retired_q;
        if (w_retire && !(&retired_q)) retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A per-instruction
//               reference model walks the architectural step list for each
//               opcode and predicts every output cycle by cycle, plus a
//               saturating count of completed instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    localparam int OPW   = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // Step identifiers of the reference model
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADDR = 2, P_MEMRD = 3,
                   P_MEMWB = 4, P_MEMWR = 5, P_REXEC = 6, P_RWB = 7,
                   P_BRANCH = 8, P_JUMP = 9, P_IEXEC = 10, P_IWB = 11,
                   P_HALT = 12;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdest;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       halted;
        logic       illegal;
    } outs_t;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_if #(.OPW(OPW), .CNT_W(CNT_W)) bus ();

    multicycle_control #(.OPW(OPW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_retired = 0;
    int ir_pulses;

    function automatic outs_t dut_outs();
        outs_t o;
        o.irwrite  = bus.irwrite;
        o.pcwrite  = bus.pcwrite;
        o.pcsrc    = bus.pcsrc;
        o.iord     = bus.iord;
        o.memread  = bus.memread;
        o.memwrite = bus.memwrite;
        o.memtoreg = bus.memtoreg;
        o.regdest  = bus.regdest;
        o.regwrite = bus.regwrite;
        o.alusrca  = bus.alusrca;
        o.alusrcb  = bus.alusrcb;
        o.aluop    = bus.aluop;
        o.halted   = bus.halted;
        o.illegal  = bus.illegal;
        return o;
    endfunction

    // Expected outputs for one step of the instruction's sequence
    function automatic outs_t exp_out(int ph, logic mr, logic z, logic [2:0] op, logic ill);
        outs_t o = '0;
        case (ph)
            P_FETCH:   begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
            P_DECODE:  o.alusrcb = 2'b11;
            P_MEMADDR: begin o.alusrca = 1; o.alusrcb = 2'b10; end
            P_MEMRD:   begin o.memread = 1; o.iord = 1; end
            P_MEMWB:   begin o.regwrite = 1; o.memtoreg = 1; end
            P_MEMWR:   begin o.memwrite = 1; o.iord = 1; end
            P_REXEC:   begin o.alusrca = 1; o.aluop = 2'b10; end
            P_RWB:     begin o.regwrite = 1; o.regdest = 1; end
            P_IEXEC:   begin o.alusrca = 1; o.alusrcb = 2'b10; end
            P_IWB:     o.regwrite = 1;
            P_BRANCH:  begin
                o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01;
                o.pcwrite = ((op == 3'd5) && z) || ((op == 3'd6) && !z);
            end
            P_JUMP:    begin o.pcsrc = 2'b10; o.pcwrite = 1; end
            P_HALT:    begin o.halted = 1; o.illegal = ill; end
            default:   ;
        endcase
        return o;
    endfunction

    function automatic int exp_retired();
`ifdef PERF_CNT_EN
        return model_retired;
`else
        return 0;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one step; wait-type steps hold mem_ready low for nwait cycles first
    task automatic step(int ph, int nwait, logic [7:0] opdrv, logic [2:0] op,
                        logic z, logic ill, string tag);
        bit waits = (ph == P_FETCH) || (ph == P_MEMRD) || (ph == P_MEMWR);
        for (int w = 0; w <= (waits ? nwait : 0); w++) begin
            bus.opcode    = opdrv;
            bus.mem_ready = waits ? (w == nwait) : 1'($urandom);
            bus.zero      = (ph == P_BRANCH) ? z : 1'($urandom);
            @(negedge clk);
            check($sformatf("%s step%0d c%0d", tag, ph, w), 32'(dut_outs()),
                  32'(exp_out(ph, bus.mem_ready, bus.zero, op, ill)));
            if (bus.irwrite) ir_pulses++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(logic [7:0] op, logic z, int fw, int mw, string tag);
        logic [2:0] lo  = op[2:0];
        logic       ill = (op[7:3] != 5'd0);
        ir_pulses = 0;
        step(P_FETCH, fw, op, lo, z, 0, tag);
        step(P_DECODE, 0, op, lo, z, 0, tag);
        if (ill || lo == 3'd0) begin
            for (int k = 0; k < 20; k++) step(P_HALT, 0, 8'($urandom), lo, z, ill, tag);
            check({tag, " retired"}, 32'(bus.retired), 32'(exp_retired()));
            return;
        end
        // Opcode is scrambled after decode: it must have no effect
        case (lo)
            3'd1: begin step(P_REXEC, 0, 8'($urandom), lo, z, 0, tag);
                        step(P_RWB, 0, 8'($urandom), lo, z, 0, tag); end
            3'd2: begin step(P_MEMADDR, 0, 8'($urandom), lo, z, 0, tag);
                        step(P_MEMRD, mw, 8'($urandom), lo, z, 0, tag);
                        step(P_MEMWB, 0, 8'($urandom), lo, z, 0, tag); end
            3'd3: begin step(P_MEMADDR, 0, 8'($urandom), lo, z, 0, tag);
                        step(P_MEMWR, mw, 8'($urandom), lo, z, 0, tag); end
            3'd4: step(P_JUMP, 0, 8'($urandom), lo, z, 0, tag);
            3'd7: begin step(P_IEXEC, 0, 8'($urandom), lo, z, 0, tag);
                        step(P_IWB, 0, 8'($urandom), lo, z, 0, tag); end
            default: step(P_BRANCH, 0, 8'($urandom), lo, z, 0, tag);
        endcase
        if (model_retired < CMAX) model_retired++;
        check({tag, " irwrite_pulses"}, 32'(ir_pulses), 32'd1);
        check({tag, " retired"}, 32'(bus.retired), 32'(exp_retired()));
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        bus.mem_ready = 1'($urandom);
        bus.zero      = 1'($urandom);
        bus.opcode    = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_retired = 0;
        check({tag, " halted"},  32'(bus.halted),  32'd0);
        check({tag, " illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, " retired"}, 32'(bus.retired), 32'd0);
    endtask

    initial begin
        outs_t e;
        reset = 1'b1;
        do_reset("rst0");

        // Directed cases
        run_instr(8'h01, 1'b0, 0, 0, "rfmt");
        run_instr(8'h02, 1'b0, 2, 3, "lw_wait");
        run_instr(8'h05, 1'b1, 0, 0, "beq_taken");
        run_instr(8'h05, 1'b0, 0, 0, "beq_not");
        run_instr(8'h06, 1'b0, 1, 0, "bne_taken");
        run_instr(8'h06, 1'b1, 0, 0, "bne_not");
        run_instr(8'h03, 1'b0, 0, 2, "sw");
        run_instr(8'h07, 1'b0, 0, 0, "addi");

        // Randomized instruction stream
        do_reset("rst1");
        for (int i = 0; i < 30; i++)
            run_instr(8'($urandom_range(1, 7)), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $sformatf("rnd%0d", i));

        // Illegal opcode and halt
        do_reset("rst2");
        run_instr(8'h04, 1'b0, 0, 0, "pre_ill");
        run_instr(8'h09, 1'b0, 0, 0, "illegal");
        do_reset("rst3");
        run_instr(8'h01, 1'b0, 0, 0, "pre_halt");
        run_instr(8'h00, 1'b0, 0, 0, "halt");

        // Reset while MEMWR waits on memory
        do_reset("rst4");
        step(P_FETCH, 0, 8'h03, 3'd3, 0, 0, "swrst");
        step(P_DECODE, 0, 8'h03, 3'd3, 0, 0, "swrst");
        step(P_MEMADDR, 0, 8'h03, 3'd3, 0, 0, "swrst");
        for (int k = 0; k < 2; k++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            check("swrst memwr_wait", 32'(dut_outs()), 32'(exp_out(P_MEMWR, 0, 0, 3'd3, 0)));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        e = exp_out(P_MEMWR, 0, 0, 3'd3, 0);
        e.memwrite = 1'b0;
        check("swrst during_reset", 32'(dut_outs()), 32'(e));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_retired = 0;
        check("swrst retired", 32'(bus.retired), 32'd0);
        run_instr(8'h01, 1'b0, 0, 0, "after_swrst");

        // Counter saturation
        do_reset("rst5");
        for (int i = 0; i < 17; i++) run_instr(8'h04, 1'b0, 0, 0, $sformatf("jsat%0d", i));
`ifdef PERF_CNT_EN
        check("sat retired", 32'(bus.retired), 32'd15);
`else
        check("sat retired", 32'(bus.retired), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath.
- Uses the same 3-bit opcode encoding as the single-cycle decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states, sharing one ALU and one memory port.
- Memory accesses use a ready handshake. Raises halt on opcode 000 or on any illegal opcode.

Parameters:
- OPW, 8, opcode field width; decode uses bits [2:0], bits [OPW-1:3] must be zero.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  OPW  opcode field from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current read/write this cycle
- irwrite  output  1  load instruction register
- pcwrite  output  1  load PC
- pcsrc  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- memtoreg  output  1  write-back data from MDR
- regdest  output  1  destination register is rd (1) or rt (0)
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A input: 0 = PC, 1 = rs
- alusrcb  output  2  ALU B input: 00 rt, 01 constant 1, 10 sign-extended immediate, 11 branch offset
- aluop  output  2  00 add, 01 subtract, 10 funct-decoded
- halted  output  1  controller is in HALT
- illegal  output  1  the halt was caused by an illegal opcode
- retired  output  CNT_W  retired-instruction count (PERF_CNT_EN only)

Behaviour:
- Opcode decode (bits [2:0]):
  - 001 R-format, 010 lw, 011 sw, 100 j, 101 beq, 110 bne, 111 addi, 000 halt.
  - Any nonzero bit in [OPW-1:3] is illegal.
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, HALT=12.
- Outputs are Moore functions of the state. pcwrite and irwrite are additionally gated by mem_ready or zero, as stated per state. Any output not listed for a state is 0.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target).
  - Latches opcode into an internal register; later states use only the latched value.
  - Next state: lw/sw go to MEMADDR, R goes to REXEC, addi to IEXEC, beq/bne to BRANCH, j to JUMP.
  - halt goes to HALT. Illegal goes to HALT and sets illegal=1.
- MEMADDR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0. Goes to FETCH.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready, then goes to FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Goes to RWB.
- RWB: regwrite=1, regdest=1, memtoreg=0. Goes to FETCH.
- IEXEC: alusrca=1, alusrcb=10, aluop=00. Goes to IWB.
- IWB: regwrite=1, regdest=0, memtoreg=0. Goes to FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pcwrite = (beq & zero) | (bne & ~zero).
  - Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.
- HALT:
  - halted=1. All strobes are 0.
  - Left only by reset. illegal holds its value while in HALT.
- Reset:
  - While reset=1, all strobes (irwrite, pcwrite, memread, memwrite, regwrite) are forced to 0.
  - On the clock edge, state goes to FETCH and illegal, halted and retired clear to 0.
  - Reset mid-operation, including during a memory wait, abandons the instruction. Nothing is retired.
- Latency per instruction, with mem_ready=1 every cycle:
  - lw 5 cycles; sw, R and addi 4; beq, bne and j 3.
  - Each cycle mem_ready=0 in a waiting state adds one cycle.
- mem_ready is ignored in states that make no memory request.
- A change on opcode after DECODE has no effect.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - retired increments by 1 on each transition from MEMWB, MEMWR, RWB, IWB, BRANCH or JUMP into FETCH.
  - Saturates at all-ones.
  - Halt and illegal opcodes are not counted.
- Undefined: retired is tied to 0 and no counter flops exist.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_HALT..OP_ADDI);
  - the state enum typedef;
  - alusrcb, pcsrc and aluop encoding constants.
- One natural sub-module: op_decode. It is combinational, maps opcode to one-hot instruction class plus illegal, and is shared with the single-cycle decoder.

Test Plan:
- R-format: reset, opcode=001, mem_ready=1 always → states 0,1,6,7,0. regwrite=1 and regdest=1 only in cycle 4. retired=1.
- lw with wait states: opcode=010, mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD → total 10 cycles. irwrite pulses exactly once. memtoreg=1 in MEMWB.
- beq/bne: beq with zero=1 → pcwrite=1, pcsrc=01 in BRANCH. beq zero=0 → pcwrite=0. bne zero=0 → pcwrite=1. Each takes 3 cycles.
- Illegal and halt: opcode=8'h09 → HALT with illegal=1, all strobes 0 for 20 cycles. opcode=000 → halted=1, illegal=0. retired is unchanged in both cases.
- Reset in the middle of MEMWR while mem_ready=0 → memwrite=0 during reset. Next state is FETCH. retired is unchanged.
- PERF_CNT_EN with CNT_W=4: run 17 j instructions → retired saturates at 15. With the macro undefined, retired stays 0.
